// File: rtl/present80_dec_pkg.sv
// present_pkg: shared PRESENT-80 definitions for the decryption core.
//   SBOX / INV_SBOX : 16x4 substitution tables (forward and inverse)
//   ROUNDS          : round count (31)
//   KEY_ROT         : key-schedule rotation amount (61)
//   state_t         : controller states IDLE, KEXP, DEC, DONE
//   s_layer_inv     : inverse S-box applied to all 16 nibbles
//   key_fwd/key_rev : one step of the key schedule, forward and reverse
package present_pkg;

    localparam int unsigned ROUNDS  = 31;
    localparam int unsigned KEY_ROT = 61;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEXP = 2'd1,
        DEC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    function automatic logic [63:0] s_layer_inv(input logic [63:0] s);
        logic [15:0][3:0] n;
        n = s;
        for (int unsigned i = 0; i < 16; i++) begin
            n[i[3:0]] = INV_SBOX[n[i[3:0]]];
        end
        return n;
    endfunction

    // Rotate left 61, S-box the top nibble, then fold in the round counter.
    function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = (k << KEY_ROT) | (k >> (80 - KEY_ROT));
        r[79:76] = SBOX[r[79:76]];
        r[19:15] = r[19:15] ^ rc;
        return r;
    endfunction

    // Exact inverse of key_fwd: steps undone in reverse order.
    function automatic logic [79:0] key_rev(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r = k;
        r[19:15] = r[19:15] ^ rc;
        r[79:76] = INV_SBOX[r[79:76]];
        r = (r >> KEY_ROT) | (r << (80 - KEY_ROT));
        return r;
    endfunction

endpackage

// File: rtl/present80_dec_if.sv
// present80_dec_if: valid/ready input and output ports of the decryption core.
//   in_valid/in_ready  : input handshake, ciphertext[63:0] and key[79:0]
//   out_valid/out_ready: output handshake, plaintext[63:0]
//   master modport: producer/consumer side; slave modport: the core.
interface present80_dec_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] ciphertext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;

    modport master (
        output in_valid, ciphertext, key, out_ready,
        input  in_ready, out_valid, plaintext
    );

    modport slave (
        input  in_valid, ciphertext, key, out_ready,
        output in_ready, out_valid, plaintext
    );

endinterface

// File: rtl/present80_dec_p_box_inv.sv
// p_box_inv: combinational inverse PRESENT bit permutation.
//   din[63:0]  : permuted state
//   dout[63:0] : dout[i] = din[16*(i mod 4) + i/4]
module p_box_inv (
    input  logic [63:0] din,
    output logic [63:0] dout
);

    for (genvar i = 0; i < 64; i++) begin : g_bit
        assign dout[i] = din[16 * (i % 4) + i / 4];
    end

endmodule

// File: rtl/present80_dec.sv
// present80_dec: iterative PRESENT-80 decryption, fixed 63-cycle latency.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   bus : slave side of present80_dec_if (ciphertext/key in, plaintext out)
// The forward key schedule is first run for 31 cycles to reach the last
// round key, after which the rounds walk the schedule backwards.
module present80_dec
    import present_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    present80_dec_if.slave    bus
);

    state_t      state;
    logic [63:0] state_reg;
    logic [79:0] key_reg;
    logic [4:0]  rnd;
    logic        whiten;

    logic [63:0] perm;
    logic [79:0] key_prev;

    p_box_inv u_p_box_inv (
        .din  (state_reg),
        .dout (perm)
    );

    assign key_prev = key_rev(key_reg, rnd);

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.plaintext = state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            key_reg   <= '0;
            rnd       <= '0;
            whiten    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state_reg <= bus.ciphertext;
                        key_reg   <= bus.key;
                        rnd       <= 5'd1;
                        state     <= KEXP;
                    end
                end
                KEXP: begin
                    key_reg <= key_fwd(key_reg, rnd);
                    rnd     <= rnd + 5'd1;
                    if (rnd == 5'(ROUNDS)) begin
                        whiten <= 1'b1;
                        state  <= DEC;
                    end
                end
                DEC: begin
                    // First DEC cycle only removes the final round key.
                    if (whiten) begin
                        state_reg <= state_reg ^ key_reg[79:16];
                        rnd       <= 5'(ROUNDS);
                        whiten    <= 1'b0;
                    end else begin
                        key_reg   <= key_prev;
                        state_reg <= s_layer_inv(perm) ^ key_prev[79:16];
                        rnd       <= rnd - 5'd1;
                        if (rnd == 5'd1) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_present80_dec.sv
// tb_present80_dec: directed self-checking bench for present80_dec using the
// four published PRESENT-80 test vectors.
module tb_present80_dec;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    present80_dec_if bus ();

    present80_dec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [63:0] ct_v  [4];
    logic [79:0] key_v [4];
    logic [63:0] pt_v  [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        tests++;
        if (bus.plaintext !== 64'h0) begin
            fails++;
            $display("FAIL reset_plaintext: got %h expected 0", bus.plaintext);
        end
        rst = 1'b0;
    endtask

    // One full transaction with out_ready high; checks latency and result.
    task automatic decrypt_check(input int v);
        int lat;
        for (int i = 0; i < 200 && bus.in_ready !== 1'b1; i++) tick();
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL idle_wait[%0d]: in_ready=%b expected 1", v, bus.in_ready);
        end
        bus.out_ready  = 1'b1;
        bus.ciphertext = ct_v[v];
        bus.key        = key_v[v];
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL accept[%0d]: in_ready=%b expected 0", v, bus.in_ready);
        end
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        tests++;
        if (lat != 63) begin
            fails++;
            $display("FAIL latency[%0d]: got %0d edges expected 63", v, lat);
        end
        tests++;
        if (bus.plaintext !== pt_v[v]) begin
            fails++;
            $display("FAIL plaintext[%0d]: got %h expected %h", v, bus.plaintext, pt_v[v]);
        end
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL handshake[%0d]: out_valid=%b in_ready=%b expected 0/1",
                     v, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_vectors();
        for (int v = 0; v < 4; v++) decrypt_check(v);
    endtask

    task automatic test_backpressure();
        int lat;
        bus.out_ready  = 1'b0;
        bus.ciphertext = ct_v[2];
        bus.key        = key_v[2];
        bus.in_valid   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (10) tick();
        // A different block offered while busy must be ignored.
        bus.ciphertext = ct_v[1];
        bus.key        = key_v[1];
        bus.in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL busy_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        lat = 13;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        tests++;
        if (lat != 63) begin
            fails++;
            $display("FAIL bp_latency: got %0d edges expected 63", lat);
        end
        tests++;
        if (bus.plaintext !== pt_v[2]) begin
            fails++;
            $display("FAIL bp_plaintext: got %h expected %h", bus.plaintext, pt_v[2]);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if (bus.out_valid !== 1'b1 || bus.plaintext !== pt_v[2] || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: out_valid=%b plaintext=%h in_ready=%b expected 1/%h/0",
                         i, bus.out_valid, bus.plaintext, bus.in_ready, pt_v[2]);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready  = 1'b1;
        bus.ciphertext = ct_v[3];
        bus.key        = key_v[3];
        bus.in_valid   = 1'b1;
        tick();                 // E0
        bus.in_valid = 1'b0;
        repeat (39) tick();     // E1..E39
        rst = 1'b1;
        tick();                 // E40
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.plaintext !== 64'h0) begin
            fails++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b plaintext=%h expected 1/0/0",
                     bus.in_ready, bus.out_valid, bus.plaintext);
        end
        rst = 1'b0;
        decrypt_check(0);
    endtask

    task automatic test_back_to_back();
        int unsigned last_cyc;
        int lat;
        last_cyc = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int v = 0; v < 4; v++) begin
            bus.ciphertext = ct_v[v];
            bus.key        = key_v[v];
            for (int i = 0; i < 200 && bus.in_ready !== 1'b1; i++) tick();
            tick();             // accept edge
            lat = 0;
            while (bus.out_valid !== 1'b1 && lat < 200) begin
                tick();
                lat++;
            end
            tests++;
            if (bus.out_valid !== 1'b1 || bus.plaintext !== pt_v[v]) begin
                fails++;
                $display("FAIL b2b_result[%0d]: out_valid=%b plaintext=%h expected 1/%h",
                         v, bus.out_valid, bus.plaintext, pt_v[v]);
            end
            // 63 edges to result, the DONE handshake edge, one IDLE cycle.
            if (v > 0) begin
                tests++;
                if (cyc - last_cyc != 65) begin
                    fails++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 65", v, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        ct_v[0] = 64'h5579C1387B228445; key_v[0] = 80'h0;                    pt_v[0] = 64'h0;
        ct_v[1] = 64'hE72C46C0F5945049; key_v[1] = 80'hFFFFFFFFFFFFFFFFFFFF; pt_v[1] = 64'h0;
        ct_v[2] = 64'hA112FFC72F68417B; key_v[2] = 80'h0;                    pt_v[2] = 64'hFFFFFFFFFFFFFFFF;
        ct_v[3] = 64'h3333DCD3213210D2; key_v[3] = 80'hFFFFFFFFFFFFFFFFFFFF; pt_v[3] = 64'hFFFFFFFFFFFFFFFF;

        bus.in_valid   = 1'b0;
        bus.ciphertext = '0;
        bus.key        = '0;
        bus.out_ready  = 1'b1;

        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
